execute_unit: RTL and testbench

- Execute stage directly downstream of register_file. Consumes its two read operands (out1/out2), performs an ALU operation or an iterative 32-cycle shift-add multiply, and registers the result.
- Returns the result with destination address and write strobe, in a form that drives register_file's in/select_in/write inputs for writeback.

---
 rtl/execute_unit_if.sv | 33 +++
 rtl/execute_unit.sv | 148 ++++++++++++++
 tb/tb_execute_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/execute_unit_if.sv
// Request/response bundle between the operand source (register_file side) and execute_unit.
// start is a request accepted only when enable=1 and busy=0; done/write_out are one-cycle result pulses with no backpressure.
interface execute_unit_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  enable;
  logic                  start;
  logic [3:0]            opcode;
  logic [WIDTH-1:0]      operand1;
  logic [WIDTH-1:0]      operand2;
  logic [ADDR_WIDTH-1:0] dest_in;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic [ADDR_WIDTH-1:0] dest_out;
  logic                  write_out;
  logic                  zero;
  logic                  carry;
  logic                  overflow;
  logic                  illegal;
  logic                  dbg_mul;

  modport master (
    output enable, start, opcode, operand1, operand2, dest_in,
    input  busy, done, result, dest_out, write_out, zero, carry, overflow, illegal, dbg_mul
  );

  modport slave (
    input  enable, start, opcode, operand1, operand2, dest_in,
    output busy, done, result, dest_out, write_out, zero, carry, overflow, illegal, dbg_mul
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus a 32-step shift-add multiplier, with registered
// result, flags and writeback strobe for register_file.
module execute_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clock,
  input  logic         reset,
  execute_unit_if.slave bus
);
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [3:0]      OP_MUL   = 4'd11;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        a_q;
  logic [2*WIDTH-1:0]      acc_q;
  logic [2*WIDTH-1:0]      acc_d;
  logic [ADDR_WIDTH-1:0]   dest_q;
  logic                    busy_q, done_q, write_q, zero_q, carry_q, ovf_q, illegal_q;
  logic [WIDTH-1:0]        result_q;
  logic [ADDR_WIDTH-1:0]   dest_out_q;

  logic [WIDTH-1:0]        alu_res;
  logic                    alu_c, alu_v, alu_ill;
  logic [WIDTH:0]          add_w;
  logic [WIDTH-1:0]        sub_w;
  logic [WIDTH:0]          mul_sum;
  logic [CNT_W-1:0]        sh;

  assign add_w = {1'b0, bus.operand1} + {1'b0, bus.operand2};
  assign sub_w = bus.operand1 - bus.operand2;
  assign sh    = bus.operand2[CNT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.opcode)
      4'd0: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != bus.operand1[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sub_w;
        alu_c   = bus.operand1 < bus.operand2;
        alu_v   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != bus.operand1[WIDTH-1]);
      end
      4'd2:  alu_res = bus.operand1 & bus.operand2;
      4'd3:  alu_res = bus.operand1 | bus.operand2;
      4'd4:  alu_res = bus.operand1 ^ bus.operand2;
      4'd5:  alu_res = ~bus.operand1;
      4'd6:  alu_res = bus.operand1 << sh;
      4'd7:  alu_res = bus.operand1 >> sh;
      4'd8:  alu_res = $unsigned($signed(bus.operand1) >>> sh);
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.operand1) < $signed(bus.operand2)};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, bus.operand1 < bus.operand2};
      default: alu_ill = 1'b1;
    endcase
  end

  // Accumulator holds {partial product, remaining multiplier bits}; each step adds A
  // into the upper half when the multiplier LSB is set, then shifts right by one.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign acc_d   = {mul_sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      acc_q      <= '0;
      dest_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      write_q    <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      result_q   <= '0;
      dest_out_q <= '0;
    end else begin
      done_q    <= 1'b0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (bus.enable) begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.opcode == OP_MUL) begin
                a_q     <= bus.operand1;
                acc_q   <= {{WIDTH{1'b0}}, bus.operand2};
                cnt_q   <= '0;
                dest_q  <= bus.dest_in;
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end else begin
                result_q   <= alu_res;
                zero_q     <= (alu_res == '0);
                carry_q    <= alu_c;
                ovf_q      <= alu_v;
                illegal_q  <= alu_ill;
                dest_out_q <= bus.dest_in;
                done_q     <= 1'b1;
                write_q    <= !alu_ill;
              end
            end
          end
          S_MUL: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              result_q   <= acc_d[WIDTH-1:0];
              zero_q     <= (acc_d[WIDTH-1:0] == '0);
              carry_q    <= 1'b0;
              ovf_q      <= |acc_d[2*WIDTH-1:WIDTH];
              dest_out_q <= dest_q;
              done_q     <= 1'b1;
              write_q    <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.dest_out  = dest_out_q;
  assign bus.write_out = write_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = illegal_q;
  assign bus.dbg_mul   = (state_q == S_MUL);
endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU vector table plus hand-written multiply,
// stall, illegal-opcode and reset sequences.
module tb_execute_unit;
  localparam int W = 32;
  localparam int A = 5;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  execute_unit_if #(.WIDTH(W), .ADDR_WIDTH(A)) bus ();

  execute_unit #(.WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [A-1:0] dest;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [A-1:0] d);
    bus.start    = st;
    bus.opcode   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.dest_in  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, {bus.busy, bus.done, bus.write_out, bus.zero, bus.carry,
                           bus.overflow, bus.illegal, bus.dest_out, bus.result}, 64'd0);
  endtask

  // Multiply driver: start pulses with junk data are issued while busy; enable dropped
  // for stall_len cycles after stall_at enabled cycles.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [A-1:0] d,
                         input int stall_at, input int stall_len,
                         input logic [W-1:0] exp_res, input logic exp_v);
    int   edges;
    logic seen;
    logic busy_drop;
    drive(1'b1, 4'd11, a, b, d);
    tick();
    check("mul.accept_busy", {bus.busy, bus.dbg_mul, bus.done, bus.write_out}, 64'b1100);
    edges = 0;
    seen = 1'b0;
    busy_drop = 1'b0;
    while (!seen && edges < 80) begin
      drive(edges[0], 4'd0, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9);
      if (edges == stall_at) bus.enable = 1'b0;
      if (edges == stall_at + stall_len) bus.enable = 1'b1;
      tick();
      edges++;
      if (bus.done || bus.write_out) seen = 1'b1;
      else if (!bus.busy) busy_drop = 1'b1;
    end
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    check("mul.latency", 64'(edges), 64'(32 + stall_len));
    check("mul.busy_held", {63'd0, busy_drop}, 64'd0);
    check("mul.result", {32'd0, bus.result}, {32'd0, exp_res});
    check("mul.flags", {bus.overflow, bus.carry, bus.zero, bus.illegal},
          {exp_v, 1'b0, exp_res == 0, 1'b0});
    check("mul.strobe", {bus.done, bus.write_out, bus.busy}, 64'b110);
    check("mul.dest", 64'(bus.dest_out), 64'(d));
    tick();
    check("mul.pulse_end", {bus.done, bus.write_out}, 64'b00);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h1,         5'd3,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd0,  32'h7FFF_FFFF, 32'h1,         5'd4,  32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd1,  32'd5,         32'd7,         5'd5,  32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'd8,  32'h8000_0000, 32'd4,         5'd6,  32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd9,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd10, 32'hFFFF_FFFF, 32'd1,         5'd1,  32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2,  32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd3,  32'h0F0F_0000, 32'h0000_00FF, 5'd8,  32'h0F0F_00FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd9,  32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd5,  32'h1234_5678, 32'h0,         5'd10, 32'hEDCB_A987, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd6,  32'h1,         32'h3F,        5'd11, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd7,  32'h8000_0000, 32'h21,        5'd12, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd1,  32'h8000_0000, 32'h1,         5'd13, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'd0,  32'h8000_0000, 32'h8000_0000, 5'd14, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'd13, 32'd5,         32'd5,         5'd15, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{4'd9,  32'd1,         32'hFFFF_FFFF, 5'd16, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles with an ADD request present
    reset = 1'b1;
    bus.enable = 1'b1;
    drive(1'b1, 4'd0, 32'd9, 32'd9, 5'd3);
    tick();
    check_all_zero("reset.c1");
    tick();
    check_all_zero("reset.c2");
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    check_all_zero("reset.idle");

    // ALU table, applied back-to-back one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      exp_q.push_back(vecs[i].res);
      tick();
      check($sformatf("vec%0d.result", i), 64'(bus.result), 64'(exp_q.pop_front()));
      check($sformatf("vec%0d.flags", i), {bus.zero, bus.carry, bus.overflow, bus.illegal},
            {vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].ill});
      check($sformatf("vec%0d.strobe", i), {bus.done, bus.write_out, bus.busy},
            {1'b1, !vecs[i].ill, 1'b0});
      if (!vecs[i].ill)
        check($sformatf("vec%0d.dest", i), 64'(bus.dest_out), 64'(vecs[i].dest));
    end
    bus.start = 1'b0;
    tick();
    check("alu.pulse_end", {bus.done, bus.write_out, bus.illegal}, 64'b000);
    check("alu.result_hold", 64'(bus.result), 64'h0);

    // Multiply, plain and small
    run_mul(32'h0001_2345, 32'h0001_0000, 5'd7, -1, 0, 32'h2345_0000, 1'b1);
    run_mul(32'd6, 32'd7, 5'd2, -1, 0, 32'd42, 1'b0);

    // Multiply with a five-cycle stall in the middle
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 10, 5, 32'h0000_0001, 1'b1);

    // Illegal opcode on its own
    drive(1'b1, 4'd15, 32'h1234, 32'h5678, 5'd4);
    tick();
    bus.start = 1'b0;
    check("ill15", {bus.done, bus.illegal, bus.write_out, bus.zero}, 64'b1101);
    check("ill15.result", 64'(bus.result), 64'h0);

    // Reset in the middle of a multiply abandons it
    drive(1'b1, 4'd11, 32'd3, 32'd5, 5'd6);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_mul");
    begin
      int strobes = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (bus.done || bus.write_out || bus.busy) strobes++;
      end
      check("rst_mul.no_done", 64'(strobes), 64'd0);
    end

    // Recovery: plain ADD after the abandoned multiply
    drive(1'b1, 4'd0, 32'd2, 32'd3, 5'd1);
    tick();
    bus.start = 1'b0;
    check("recover.add", {bus.done, bus.write_out, bus.dest_out, bus.result}, {2'b11, 5'd1, 32'd5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
